// File: rtl/mips_pkg.sv
// Shared encodings for the fetch stage: next-PC select codes, fetch FSM
// states and the default reset vector.
package mips_pkg;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] ST_BOOT = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b10;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selector: sequential, PC-relative branch,
// pseudo-direct jump and register-indirect targets, all modulo 2^32.
module pc_next
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm,
  input  logic [25:0] j_addr,
  input  logic [31:0] reg_target,
  output logic [31:0] pc4,
  output logic [31:0] target
);

  always_comb begin
    pc4    = pc + 32'd4;
    target = pc4;
    case (pc_src)
      PCSRC_SEQ:    target = pc4;
      // imm counts words, so the byte offset is imm << 2
      PCSRC_BRANCH: target = pc4 + {imm[29:0], 2'b00};
      PCSRC_JUMP:   target = {pc4[31:28], j_addr, 2'b00};
      PCSRC_REG:    target = reg_target;
      default:      target = pc4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Program counter, BOOT/RUN/HALT fetch FSM and advance counter.
// Optional PC_ALIGN_CHECK_EN halts on a misaligned target instead of masking it.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_wre,
  input  logic [1:0]  pc_src,
  input  logic [31:0] imm,
  input  logic [25:0] j_addr,
  input  logic [31:0] reg_target,
  input  logic        halt,
  output logic [31:0] i_addr,
  output logic [31:0] pc4,
  output logic        fetch_valid,
  output logic [31:0] ins_count,
  output logic        align_err
);

  logic [1:0]  state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ins_count_reg;
  logic [31:0] target;
  logic [31:0] pc_load_val;
  logic        load_req;
  logic        load_pc;
  logic        go_halt;

  pc_next u_pc_next (
    .pc         (pc_reg),
    .pc_src     (pc_src),
    .imm        (imm),
    .j_addr     (j_addr),
    .reg_target (reg_target),
    .pc4        (pc4),
    .target     (target)
  );

  // A halt decoded during a stall is dropped, not deferred.
  assign load_req = (state_reg == ST_RUN) && pc_wre && !halt;

`ifdef PC_ALIGN_CHECK_EN
  logic align_fault;
  logic align_err_reg;

  assign align_fault = load_req && !is_word_aligned(target);
  assign load_pc     = load_req && !align_fault;
  assign pc_load_val = target;
  assign go_halt     = (state_reg == ST_RUN) && pc_wre && (halt || align_fault);
  assign align_err   = align_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      align_err_reg <= 1'b0;
    else if (align_fault)
      align_err_reg <= 1'b1;
  end
`else
  assign load_pc     = load_req;
  assign pc_load_val = target & ~32'h3;
  assign go_halt     = (state_reg == ST_RUN) && pc_wre && halt;
  assign align_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_BOOT;
      pc_reg        <= RESET_PC;
      ins_count_reg <= 32'd0;
    end else begin
      case (state_reg)
        ST_BOOT: state_reg <= ST_RUN;
        ST_RUN:  if (go_halt) state_reg <= ST_HALT;
        ST_HALT: state_reg <= ST_HALT;
        default: state_reg <= ST_HALT;
      endcase
      if (load_pc) begin
        pc_reg        <= pc_load_val;
        ins_count_reg <= ins_count_reg + 32'd1;
      end
    end
  end

  assign i_addr      = pc_reg;
  assign fetch_valid = (state_reg == ST_RUN);
  assign ins_count   = ins_count_reg;

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 CLK  in  1  single clock; all state updates on the rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 PCWre  in  1  PC write enable; 0 = stall and hold PC.
REQ-005 PCSrc  in  2  next-PC select: 00 = PC+4, 01 = branch, 10 = jump, 11 = register.
REQ-006 Imm  in  32  sign-extended branch offset, in words.
REQ-007 JAddr  in  26  jump target field.
REQ-008 RegTarget  in  32  jump-register target.
REQ-009 Halt  in  1  halt instruction decoded this cycle.
REQ-010 IAddr  out  32  current PC, byte address to instruction memory.
REQ-011 PC4  out  32  current PC+4, link value.
REQ-012 FetchValid  out  1  IAddr holds a valid fetch this cycle.
REQ-013 InsCount  out  32  count of PC advances since reset.
REQ-014 AlignErr  out  1  sticky misaligned-target flag.

Function
REQ-015 The block SHALL use three states: BOOT, RUN, HALT.
REQ-016 BOOT SHALL last exactly one cycle after Reset deasserts, with FetchValid=0 and PC=RESET_PC held; it SHALL then go to RUN unconditionally.
REQ-017 In RUN, FetchValid SHALL be 1 and the PC SHALL load the next-PC value on each edge with PCWre=1.
REQ-018 Next-PC values: 00 → PC+4; 01 → PC+4+(Imm<<2); 10 → {PC4[31:28], JAddr, 2'b00}; 11 → RegTarget.
REQ-019 All address arithmetic SHALL be modulo 2^32; PC=32'hFFFF_FFFC with PCSrc=00 SHALL wrap to 0.
REQ-020 PC4 and IAddr SHALL be combinational from the PC register, so the PC change is visible the same cycle after the edge (zero added latency).
REQ-021 With PCWre=0 in RUN, the PC, InsCount and state SHALL hold, and FetchValid SHALL stay 1.
REQ-022 Halt=1 with PCWre=1 in RUN SHALL:
- hold the PC;
- not increment InsCount;
- enter HALT.
REQ-023 Halt=1 with PCWre=0 SHALL be ignored.
REQ-024 HALT SHALL be sticky until reset: PC held, FetchValid=0, all inputs ignored.
REQ-025 InsCount SHALL increment by 1 on each edge where the PC loads in RUN, and SHALL wrap from 32'hFFFF_FFFF to 0.

Reset
REQ-026 Reset=0 SHALL asynchronously force:
- PC=RESET_PC;
- state=BOOT;
- InsCount=0;
- AlignErr=0;
- FetchValid=0.
REQ-027 Reset asserted mid-stall or in HALT SHALL take effect immediately, with no pending update surviving.
REQ-028 Reset deassertion SHALL be sampled on CLK; the first RUN cycle is the second edge after release.

Configuration
REQ-029 Macro PC_ALIGN_CHECK_EN, when defined:
- a PC load whose target has [1:0]≠00 SHALL not update the PC;
- it SHALL set AlignErr=1 and enter HALT.
REQ-030 Without PC_ALIGN_CHECK_EN:
- target[1:0] SHALL be forced to 00 before loading;
- AlignErr SHALL be tied 0;
- the port list SHALL be unchanged.

Structure
REQ-031 Shared package mips_pkg SHALL hold the PCSrc encodings, the BOOT/RUN/HALT state encoding and the default RESET_PC constant.
REQ-032 Next-PC selection SHALL be a combinational sub-module pc_next; pc_fetch SHALL hold the PC register, state machine and counter.

Verification
REQ-033 The bench SHALL cover these scenarios:
- Reset release, PCSrc=00, PCWre=1 → cycle 1 FetchValid=0, IAddr=0; then IAddr 0,4,8,C; InsCount 0,1,2,3.
- PC=0x10, PCSrc=01, Imm=32'hFFFF_FFFE → next IAddr=0x0C; with Imm=3 → next IAddr=0x20.
- PC=0x3000_0040, PCSrc=10, JAddr=26'h0000100 → next IAddr=0x3000_0400; PC=0xFFFF_FFFC with PCSrc=00 → next IAddr=0.
- PCWre=0 for 3 cycles with Halt=1 → IAddr and InsCount unchanged, no HALT; then PCWre=1, Halt=1 → HALT, FetchValid=0 thereafter.
- PCSrc=11, RegTarget=0x0000_0022 → with macro: IAddr unchanged, AlignErr=1, HALT; without macro: IAddr=0x20, AlignErr=0.
- Reset asserted mid-HALT → IAddr=RESET_PC, InsCount=0, AlignErr=0 immediately, without waiting for an edge.
